// File: rtl/serial_shift_unit.sv
// Serial barrel-free shifter: requests queue in a small FIFO and are shifted
// one bit per cycle, with results held on the writeback port until acknowledged.
module serial_shift_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int ID_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_new_request,
  input  logic [ID_W-1:0] issue_id,
  input  logic [31:0]     issue_rs1,
  input  logic [4:0]      issue_shamt,
  input  logic [1:0]      issue_op,
  output logic            issue_ready,
  output logic            wb_done,
  output logic [ID_W-1:0] wb_id,
  output logic [31:0]     wb_rd,
  input  logic            wb_ack
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [ID_W-1:0] q_id    [FIFO_DEPTH];
  logic [31:0]     q_rs1   [FIFO_DEPTH];
  logic [4:0]      q_shamt [FIFO_DEPTH];
  logic [1:0]      q_op    [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  state_t           state;

  logic [31:0]     work;
  logic [4:0]      cnt;
  logic [1:0]      op;
  logic [ID_W-1:0] id_r;

  logic push, pop;

  // Single-bit step; op 2'b10 falls through to a logical right shift.
  function automatic logic [31:0] shift_step(input logic [31:0] v, input logic [1:0] o);
    case (o)
      2'b00:   shift_step = {v[30:0], 1'b0};
      2'b11:   shift_step = {v[31], v[31:1]};
      default: shift_step = {1'b0, v[31:1]};
    endcase
  endfunction

  assign issue_ready = (count != FULL);
  assign push        = issue_new_request & issue_ready & ~rst;
  assign pop         = (state == IDLE) && (count != '0);

  // Control: queue pointers, FSM and the writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= IDLE;
      wb_done <= 1'b0;
      wb_id   <= '0;
      wb_rd   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

      case (state)
        IDLE: begin
          if (pop) begin
            if (q_shamt[rd_ptr] == 5'd0) begin
              state   <= DONE;
              wb_done <= 1'b1;
              wb_id   <= q_id[rd_ptr];
              wb_rd   <= q_rs1[rd_ptr];
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (cnt == 5'd1) begin
            state   <= DONE;
            wb_done <= 1'b1;
            wb_id   <= id_r;
            wb_rd   <= shift_step(work, op);
          end
        end
        DONE: begin
          if (wb_ack) begin
            state   <= IDLE;
            wb_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: queue storage and the working shift register
  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]    <= issue_id;
      q_rs1[wr_ptr]   <= issue_rs1;
      q_shamt[wr_ptr] <= issue_shamt;
      q_op[wr_ptr]    <= issue_op;
    end
    if (pop) begin
      work <= q_rs1[rd_ptr];
      cnt  <= q_shamt[rd_ptr];
      op   <= q_op[rd_ptr];
      id_r <= q_id[rd_ptr];
    end else if (state == SHIFT) begin
      work <= shift_step(work, op);
      cnt  <= cnt - 5'd1;
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Bench for serial_shift_unit: queue/job-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_serial_shift_unit;

  localparam int DEPTH = 2;
  localparam int ID_W  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_new_request;
  logic [ID_W-1:0] issue_id;
  logic [31:0]     issue_rs1;
  logic [4:0]      issue_shamt;
  logic [1:0]      issue_op;
  logic            issue_ready;
  logic            wb_done;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_rd;
  logic            wb_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_shift_unit #(.FIFO_DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .issue_new_request(issue_new_request), .issue_id(issue_id),
    .issue_rs1(issue_rs1), .issue_shamt(issue_shamt), .issue_op(issue_op),
    .issue_ready(issue_ready), .wb_done(wb_done), .wb_id(wb_id),
    .wb_rd(wb_rd), .wb_ack(wb_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int s, input logic [1:0] o);
    logic signed [31:0] sv;
    sv = v;
    case (o)
      2'b00:   return v << s;
      2'b11:   return sv >>> s;
      default: return v >> s;
    endcase
  endfunction

  // Reference model: queue of accepted jobs, one job in service at a time
  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     res;
    int              shamt;
  } job_t;

  job_t            q[$];
  job_t            cur;
  bit              busy = 0, done_m = 0, model_valid = 0;
  int              rem = 0;
  logic [ID_W-1:0] m_id = '0;
  logic [31:0]     m_rd = '0;

  always @(posedge clk) begin
    bit   rdy;
    job_t nj;
    rdy = (q.size() < DEPTH);
    if (rst) begin
      q.delete();
      busy = 0; done_m = 0; m_id = '0; m_rd = '0; model_valid = 1;
    end else begin
      if (!busy) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          busy = 1; rem = cur.shamt; done_m = (rem == 0);
          if (done_m) begin m_id = cur.id; m_rd = cur.res; end
        end
      end else if (!done_m) begin
        rem--;
        if (rem == 0) begin done_m = 1; m_id = cur.id; m_rd = cur.res; end
      end else if (wb_ack) begin
        busy = 0; done_m = 0;
      end
      if (issue_new_request && rdy) begin
        nj.id = issue_id;
        nj.res = ref_shift(issue_rs1, int'(issue_shamt), issue_op);
        nj.shamt = int'(issue_shamt);
        q.push_back(nj);
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_ready", issue_ready, (q.size() < DEPTH));
      chk("m_done", wb_done, done_m);
      chk("m_id", wb_id, m_id);
      chk("m_rd", wb_rd, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until the unit takes it; leaves issue_new_request high.
  task automatic send(input logic [ID_W-1:0] id, input logic [31:0] rs1,
                      input logic [4:0] sh, input logic [1:0] o);
    bit acc;
    int k;
    issue_new_request = 1'b1;
    issue_id = id; issue_rs1 = rs1; issue_shamt = sh; issue_op = o;
    acc = 0; k = 0;
    do begin
      acc = issue_ready;
      tick();
      k++;
    end while (!acc && k < 50);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic run_one(input logic [ID_W-1:0] id, input logic [31:0] rs1,
                         input logic [4:0] sh, input logic [1:0] o, input logic [31:0] exp_rd);
    int n;
    send(id, rs1, sh, o);
    issue_new_request = 1'b0;
    n = 1;
    while (!wb_done && n < 100) begin tick(); n++; end
    chk("latency", n, 2 + int'(sh));
    chk("result_rd", wb_rd, exp_rd);
    chk("result_id", wb_id, id);
    wb_ack = 1'b1; tick(); wb_ack = 1'b0;
    chk("idle_after_ack", wb_done, 1'b0);
  endtask

  initial begin
    int n, got;
    bit acc;
    rst = 1'b1; issue_new_request = 1'b0; wb_ack = 1'b0;
    issue_id = '0; issue_rs1 = '0; issue_shamt = '0; issue_op = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_ready", issue_ready, 1'b1);
    chk("reset_done", wb_done, 1'b0);
    chk("reset_id", wb_id, 0);
    chk("reset_rd", wb_rd, 0);

    run_one(4'd3, 32'h0000_00F0, 5'd4,  2'b00, 32'h0000_0F00);
    run_one(4'd5, 32'h8000_0000, 5'd31, 2'b11, 32'hFFFF_FFFF);
    run_one(4'd6, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
    run_one(4'd7, 32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678);
    run_one(4'd8, 32'h8000_0010, 5'd4,  2'b10, 32'h0800_0001);

    // Result held stable across a stalled writeback
    send(4'd9, 32'hA5A5_0003, 5'd3, 2'b11);
    issue_new_request = 1'b0;
    n = 0;
    while (!wb_done && n < 100) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_done", wb_done, 1'b1);
      chk("hold_id", wb_id, 4'd9);
      chk("hold_rd", wb_rd, 32'hF4B4_A000);
      tick();
    end
    wb_ack = 1'b1; tick(); wb_ack = 1'b0;
    chk("hold_released", wb_done, 1'b0);
    tick();

    // Backpressure: queue fills while writeback stalls; held request not lost
    send(4'd1, 32'h0000_0001, 5'd1, 2'b00);
    send(4'd2, 32'h0000_0002, 5'd1, 2'b00);
    send(4'd3, 32'h0000_0003, 5'd1, 2'b00);
    chk("full_ready", issue_ready, 1'b0);
    chk("full_done", wb_done, 1'b1);
    issue_id = 4'd4; issue_rs1 = 32'h0000_0004; issue_shamt = 5'd1; issue_op = 2'b01;
    repeat (3) tick();
    chk("held_ready", issue_ready, 1'b0);
    got = 0; acc = 0; n = 0;
    while (got < 4 && n < 200) begin
      if (issue_new_request && issue_ready) acc = 1;
      wb_ack = wb_done;
      if (wb_done) begin
        chk("order_id", wb_id, got + 1);
        got++;
      end
      tick();
      n++;
      if (acc) issue_new_request = 1'b0;
    end
    wb_ack = 1'b0;
    chk("order_count", got, 4);
    tick();

    // Reset mid-shift with a full queue and a request in the reset cycle
    send(4'd10, 32'hFFFF_0000, 5'd20, 2'b01);
    send(4'd11, 32'h0000_FFFF, 5'd20, 2'b00);
    send(4'd12, 32'h1111_1111, 5'd20, 2'b11);
    issue_new_request = 1'b0;
    repeat (3) tick();
    rst = 1'b1; issue_new_request = 1'b1; issue_id = 4'd13;
    tick();
    rst = 1'b0; issue_new_request = 1'b0;
    chk("rst_done", wb_done, 1'b0);
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_rd", wb_rd, 0);
    for (int i = 0; i < 40; i++) begin
      chk("no_stale", wb_done, 1'b0);
      tick();
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      issue_new_request = $urandom_range(0, 1);
      issue_id = ID_W'($urandom);
      issue_rs1 = $urandom;
      issue_shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
      issue_op = 2'($urandom_range(0, 3));
      wb_ack = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; issue_new_request = 1'b0; wb_ack = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
